// File: rtl/pipelined_multi_operand_adder.sv
// Two-stage pipelined N_OPS-operand adder: carry-save reduction, then a carry-propagate add.
// Define MOA_SIGNED_EN to treat operands as two's complement (sign-extended); default is unsigned.
module pipelined_multi_operand_adder #(
  parameter int WIDTH = 4,
  parameter int N_OPS = 4,
  parameter int OUT_W = WIDTH + $clog2(N_OPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] ops_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       sum_out,
  output logic                   busy
);

  logic [OUT_W-1:0] ext_ops [N_OPS];
  logic [OUT_W-1:0] csa_sum;
  logic [OUT_W-1:0] csa_carry;
  logic [OUT_W-1:0] t_sum;
  logic [OUT_W-1:0] t_carry;

  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_sum_q, s1_sum_d;
  logic [OUT_W-1:0] s1_carry_q, s1_carry_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic             s1_adv;
  logic             s2_adv;

  always_comb begin
    for (int i = 0; i < N_OPS; i++) begin
`ifdef MOA_SIGNED_EN
      ext_ops[i] = {{(OUT_W-WIDTH){ops_in[i*WIDTH+WIDTH-1]}}, ops_in[i*WIDTH +: WIDTH]};
`else
      ext_ops[i] = {{(OUT_W-WIDTH){1'b0}}, ops_in[i*WIDTH +: WIDTH]};
`endif
    end
  end

  // 3:2 compressors fold each further operand into the (sum, carry) pair; carries
  // shifted past OUT_W are dropped, which keeps the result exact modulo 2^OUT_W.
  always_comb begin
    csa_sum   = ext_ops[0];
    csa_carry = ext_ops[1];
    t_sum     = '0;
    t_carry   = '0;
    for (int i = 2; i < N_OPS; i++) begin
      t_sum     = csa_sum ^ csa_carry ^ ext_ops[i];
      t_carry   = ((csa_sum & csa_carry) | (csa_sum & ext_ops[i]) |
                   (csa_carry & ext_ops[i])) << 1;
      csa_sum   = t_sum;
      csa_carry = t_carry;
    end
  end

  // Handshake: a transfer happens on valid && ready at a rising edge. Each stage
  // advances when it is empty or the stage after it advances; in_ready depends only
  // on out_ready and the stage valid bits, never on in_valid.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv;

    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_carry_d = s1_carry_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d   = csa_sum;
        s1_carry_d = csa_carry;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d = s1_sum_q + s1_carry_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_carry_q <= s1_carry_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sum_out   = sum_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_pipelined_multi_operand_adder.sv
// Bench for pipelined_multi_operand_adder: directed vectors, backpressure, reset,
// parameter sweep and random traffic, checked by a queue-based scoreboard.
module tb_pipelined_multi_operand_adder;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int OW = 6;

`ifdef MOA_SIGNED_EN
  localparam logic [OW-1:0] E_A55A = 6'h3E;
  localparam logic [OW-1:0] E_8421 = 6'h3F;
  localparam logic [OW-1:0] E_8000 = 6'h38;
  localparam logic [10:0]   E_SW8  = 11'h7FB;
  localparam logic [5:0]    E_SW4  = 6'h3D;
`else
  localparam logic [OW-1:0] E_A55A = 6'h1E;
  localparam logic [OW-1:0] E_8421 = 6'h0F;
  localparam logic [OW-1:0] E_8000 = 6'h08;
  localparam logic [10:0]   E_SW8  = 11'h4FB;
  localparam logic [5:0]    E_SW4  = 6'h2D;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] ops_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [OW-1:0]  sum_out;
  logic           busy;

  pipelined_multi_operand_adder #(.WIDTH(W), .N_OPS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ops_in(ops_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out), .busy(busy)
  );

  logic        sw_valid = 1'b0;
  logic [39:0] sw8_ops = '0;
  logic [11:0] sw4_ops = '0;
  logic        sw8_in_ready, sw8_out_valid, sw8_busy;
  logic [10:0] sw8_sum;
  logic        sw4_in_ready, sw4_out_valid, sw4_busy;
  logic [5:0]  sw4_sum;

  pipelined_multi_operand_adder #(.WIDTH(8), .N_OPS(5)) u_sw8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw8_in_ready), .ops_in(sw8_ops),
    .out_valid(sw8_out_valid), .out_ready(1'b1), .sum_out(sw8_sum), .busy(sw8_busy)
  );

  pipelined_multi_operand_adder #(.WIDTH(4), .N_OPS(3)) u_sw4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw4_in_ready), .ops_in(sw4_ops),
    .out_valid(sw4_out_valid), .out_ready(1'b1), .sum_out(sw4_sum), .busy(sw4_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [OW-1:0] exp_q[$];
  int acc_q[$];
  int cyc = 0;
  bit lat_en = 1'b0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  function automatic logic [N*W-1:0] mk4(input logic [3:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [OW-1:0] ref_sum(input logic [N*W-1:0] v);
    longint s = 0;
    logic [W-1:0] o;
    for (int i = 0; i < N; i++) begin
      o = v[i*W +: W];
`ifdef MOA_SIGNED_EN
      s += longint'($signed(o));
`else
      s += longint'(o);
`endif
    end
    return OW'(s);
  endfunction

  // driver: offer one vector, starting just after a rising edge
  task automatic send(input logic [N*W-1:0] v, input logic [OW-1:0] e);
    int waited = 0;
    in_valid = 1'b1;
    ops_in   = v;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin : monitor
    bit prev_stall;
    logic [OW-1:0] held;
    logic [OW-1:0] e;
    int a;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_hold", out_valid, 1);
          check("stall_sum_hold", sum_out, held);
        end
        prev_stall = out_valid && !out_ready;
        held = sum_out;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("result", sum_out, e);
            if (lat_en) check("latency", cyc - a, 2);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N*W-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sw8_in_ready", sw8_in_ready, 1);
    check("rst_sw4_in_ready", sw4_in_ready, 1);
    @(posedge clk);
    #1;

    // back-to-back stream with out_ready high
    lat_en = 1'b1;
    send(mk4(4'h1, 4'h2, 4'h3, 4'h4), 6'h0A);
    send(mk4(4'hF, 4'hF, 4'hF, 4'hF), 6'h3C);
    send(mk4(4'h0, 4'h0, 4'h0, 4'h0), 6'h00);
    send(mk4(4'hA, 4'h5, 4'h5, 4'hA), E_A55A);
    send(mk4(4'h8, 4'h4, 4'h2, 4'h1), E_8421);
    send(mk4(4'h8, 4'h0, 4'h0, 4'h0), E_8000);
    drain();
    lat_en = 1'b0;

    // backpressure: two entries of buffering, third waits
    out_ready = 1'b0;
    send(mk4(4'h1, 4'h2, 4'h3, 4'h4), 6'h0A);
    send(mk4(4'hF, 4'hF, 4'hF, 4'hF), 6'h3C);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_out_valid", out_valid, 1);
    check("bp_sum_out", sum_out, 6'h0A);
    fork
      send(mk4(4'h8, 4'h4, 4'h2, 4'h1), E_8421);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset while vectors are in flight
    in_valid = 1'b1;
    ops_in = mk4(4'h3, 4'h3, 4'h3, 4'h3);
    @(posedge clk);
    #1;
    ops_in = mk4(4'h7, 4'h1, 4'h2, 4'h5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum_out", sum_out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // parameter sweep instances
    sw_valid = 1'b1;
    sw8_ops = {5{8'hFF}};
    sw4_ops = 12'hFFF;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (sw8_out_valid) break;
    end
    check("sw8_out_valid", sw8_out_valid, 1);
    check("sw8_sum", sw8_sum, E_SW8);
    check("sw4_out_valid", sw4_out_valid, 1);
    check("sw4_sum", sw4_sum, E_SW4);
    @(posedge clk);
    #1;

    // random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, 15));
      send(v, ref_sum(v));
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
